// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with single-cycle logic/arith/shift ops and
// an iterative unsigned multiply/divide engine feeding the HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,  OP_OR    = 4'd1,  OP_NOR  = 4'd2,  OP_ADD  = 4'd3,
    OP_SUB   = 4'd4,  OP_SLL   = 4'd5,  OP_SRL  = 4'd6,  OP_LUI  = 4'd7,
    OP_SLT   = 4'd8,  OP_SRA   = 4'd9,  OP_MULTU = 4'd10, OP_DIVU = 4'd11,
    OP_MFHI  = 4'd12, OP_MFLO  = 4'd13
  } op_t;

  state_t             state;
  logic [SHW-1:0]     count;
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor
  logic [WIDTH-1:0]   work_hi;  // partial product high half / partial remainder
  logic [WIDTH-1:0]   work_lo;  // multiplier bits / dividend shifting into quotient

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;

  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n;
  logic [WIDTH-1:0]   mul_lo_n;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_hi_n;
  logic [WIDTH-1:0]   div_lo_n;

  assign in_ready = (state == IDLE);

  // Single-cycle operation result and signed overflow
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = a + b;
    diff    = a - b;
    case (op_t'(operation))
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_add   = work_lo[0] ? opnd : '0;
    mul_sum   = {1'b0, work_hi} + {1'b0, mul_add};
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], work_lo[WIDTH-1:1]};
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ok    = ~div_diff[WIDTH];
    div_hi_n  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_n  = {work_lo[WIDTH-2:0], div_ok};
  end

  // Control FSM with registered results and HI/LO update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      opnd      <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      result    <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op_t'(operation) == OP_MULTU) begin
              work_hi <= '0;
              work_lo <= b;
              opnd    <= a;
              count   <= SHW'(WIDTH - 1);
              state   <= MUL;
            end else if (op_t'(operation) == OP_DIVU) begin
              work_hi <= '0;
              work_lo <= a;
              opnd    <= b;
              count   <= SHW'(WIDTH - 1);
              state   <= DIV;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          work_hi <= mul_hi_n;
          work_lo <= mul_lo_n;
          count   <= count - 1'b1;
          if (count == '0) begin
            hi        <= mul_hi_n;
            lo        <= mul_lo_n;
            result    <= mul_lo_n;
            zero      <= (mul_lo_n == '0);
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        DIV: begin
          work_hi <= div_hi_n;
          work_lo <= div_lo_n;
          count   <= count - 1'b1;
          if (count == '0) begin
            hi        <= div_hi_n;
            lo        <= div_lo_n;
            result    <= div_lo_n;
            zero      <= (div_lo_n == '0);
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic [31:0] result;
  logic        zero, overflow;
  logic [31:0] hi, lo;

  logic        in_valid_8;
  logic        in_ready_8;
  logic [3:0]  op_8;
  logic [7:0]  a_8, b_8;
  logic [2:0]  shamt_8;
  logic        out_valid_8;
  logic [7:0]  result_8;
  logic        zero_8, overflow_8;
  logic [7:0]  hi_8, lo_8;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(op), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid),
    .result(result), .zero(zero), .overflow(overflow), .hi(hi), .lo(lo)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .operation(op_8), .a(a_8), .b(b_8), .shamt(shamt_8), .out_valid(out_valid_8),
    .result(result_8), .zero(zero_8), .overflow(overflow_8), .hi(hi_8), .lo(lo_8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request for one edge; returns 1 time unit after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s);
    in_valid = 1'b1; op = o; a = x; b = y; shamt = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid of an iterative op; checks latency and busy span.
  task automatic wait_done(input string tag);
    int n = 0;
    int low = 0;
    while (!out_valid && n < 200) begin
      if (!in_ready) low++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, 32);
    check({tag, " busy"}, low, 32);
    check({tag, " ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int seen;
    int n;
    reset = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    in_valid_8 = 1'b0; op_8 = '0; a_8 = '0; b_8 = '0; shamt_8 = '0;
    repeat (2) @(posedge clk); #1;
    check("rst result", result, 32'h0);
    check("rst zero", zero, 1'b1);
    check("rst ovf", overflow, 1'b0);
    check("rst valid", out_valid, 1'b0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    check("rst ready", in_ready, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;

    issue(4'd3, 32'h7FFF_FFFF, 32'h1, 5'd0);
    check("add valid", out_valid, 1'b1);
    check("add result", result, 32'h8000_0000);
    check("add ovf", overflow, 1'b1);
    check("add zero", zero, 1'b0);
    issue(4'd4, 32'd5, 32'd5, 5'd0);
    check("sub valid", out_valid, 1'b1);
    check("sub result", result, 32'h0);
    check("sub zero", zero, 1'b1);
    check("sub ovf", overflow, 1'b0);
    issue(4'd4, 32'h8000_0000, 32'h1, 5'd0);
    check("sub ovf result", result, 32'h7FFF_FFFF);
    check("sub ovf flag", overflow, 1'b1);
    issue(4'd9, 32'h8000_0000, 32'h0, 5'd4);
    check("sra", result, 32'hF800_0000);
    issue(4'd6, 32'h8000_0000, 32'h0, 5'd4);
    check("srl", result, 32'h0800_0000);
    issue(4'd8, 32'hFFFF_FFFF, 32'h1, 5'd0);
    check("slt", result, 32'h1);
    issue(4'd8, 32'h1, 32'hFFFF_FFFF, 5'd0);
    check("slt false", result, 32'h0);
    issue(4'd7, 32'h0, 32'h0000_1234, 5'd0);
    check("lui", result, 32'h1234_0000);
    issue(4'd5, 32'hA5A5_0001, 32'h0, 5'd0);
    check("sll 0", result, 32'hA5A5_0001);
    issue(4'd5, 32'h1, 32'h0, 5'd31);
    check("sll 31", result, 32'h8000_0000);
    issue(4'd2, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);
    check("nor", result, 32'hF0F0_FF0F);
    issue(4'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    check("and", result, 32'h0F00_0F00);
    @(posedge clk); #1;
    check("valid pulse", out_valid, 1'b0);

    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    check("mul busy", in_ready, 1'b0);
    wait_done("mul");
    check("mul hi", hi, 32'hFFFF_FFFE);
    check("mul lo", lo, 32'h0000_0001);
    check("mul result", result, 32'h1);
    @(posedge clk); #1;
    check("mul pulse", out_valid, 1'b0);
    issue(4'd12, 32'h0, 32'h0, 5'd0);
    check("mfhi", result, 32'hFFFF_FFFE);
    issue(4'd13, 32'h0, 32'h0, 5'd0);
    check("mflo", result, 32'h1);

    issue(4'd11, 32'd100, 32'd7, 5'd0);
    wait_done("div");
    check("div lo", lo, 32'd14);
    check("div hi", hi, 32'd2);
    check("div result", result, 32'd14);
    issue(4'd1, 32'h1, 32'h2, 5'd0);
    check("hi kept", hi, 32'd2);

    issue(4'd11, 32'h1234, 32'h0, 5'd0);
    wait_done("div0");
    check("div0 lo", lo, 32'hFFFF_FFFF);
    check("div0 hi", hi, 32'h1234);
    check("div0 zero", zero, 1'b0);

    issue(4'd10, 32'd3, 32'd5, 5'd0);
    repeat (9) begin @(posedge clk); #1; end
    check("mid busy", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    check("abort ready", in_ready, 1'b1);
    #2;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort no valid", seen, 0);
    check("abort ready after", in_ready, 1'b1);
    issue(4'd3, 32'd2, 32'd3, 5'd0);
    check("post add valid", out_valid, 1'b1);
    check("post add", result, 32'd5);

    in_valid_8 = 1'b1; op_8 = 4'd10; a_8 = 8'hFF; b_8 = 8'hFF;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    n = 0;
    while (!out_valid_8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8 latency", n, 8);
    check("w8 hi", hi_8, 8'hFE);
    check("w8 lo", lo_8, 8'h01);
    in_valid_8 = 1'b1; op_8 = 4'd1; a_8 = 8'h0F; b_8 = 8'h30;
    @(posedge clk); #1;
    check("w8 or", result_8, 8'h3F);
    op_8 = 4'd15;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    check("w8 undef valid", out_valid_8, 1'b1);
    check("w8 undef result", result_8, 8'h00);
    check("w8 undef zero", zero_8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
